// File: rtl/cmp_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmp_rr_arbiter_pkg
// Description : Shared state encodings and default sizing for the shared
//               comparator round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cmp_rr_arbiter_pkg;

    localparam int c_DEF_N   = 10;
    localparam int c_DEF_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cmp_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cmp_rr_arbiter_if
// Description : Requester-side bundle of the shared comparator arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface cmp_rr_arbiter_if
    import cmp_rr_arbiter_pkg::*;
#(
    parameter int N   = c_DEF_N,
    parameter int REQ = c_DEF_REQ
) ();

    logic [REQ-1:0]   req;
    logic [REQ*N-1:0] a_in;
    logic [REQ*N-1:0] b_in;
    logic [REQ-1:0]   gnt;
    logic [REQ-1:0]   done;
    logic             L_T;
    logic             G_T;
    logic             E;
    logic             busy;

    modport master (
        output req, a_in, b_in,
        input  gnt, done, L_T, G_T, E, busy
    );

    modport slave (
        input  req, a_in, b_in,
        output gnt, done, L_T, G_T, E, busy
    );

endinterface
`default_nettype wire

// File: rtl/n_bit_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module      : n_bit_magnitude_comparator
// Description : Unsigned N-bit magnitude comparator, purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module n_bit_magnitude_comparator #(
    parameter int N = 10
) (
    input  wire logic [N-1:0] i_a,
    input  wire logic [N-1:0] i_b,
    output logic              o_lt,
    output logic              o_gt,
    output logic              o_eq
);

    assign o_lt = (i_a <  i_b);
    assign o_gt = (i_a >  i_b);
    assign o_eq = (i_a == i_b);

endmodule
`default_nettype wire

// File: rtl/cmp_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cmp_rr_arbiter
// Description : Round-robin sharing of one magnitude comparator among REQ
//               requesters; IDLE -> CMP -> RESP, one compare per 3 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_rr_arbiter
    import cmp_rr_arbiter_pkg::*;
#(
    parameter int N   = c_DEF_N,
    parameter int REQ = c_DEF_REQ
) (
    input  wire logic     clk,
    input  wire logic     rst,
    cmp_rr_arbiter_if.slave bus
);

    localparam int             c_REQ_W = (REQ > 1) ? $clog2(REQ) : 1;
    localparam logic [REQ-1:0] c_ONE   = {{(REQ-1){1'b0}}, 1'b1};

    state_t               r_state, w_state_nxt;
    logic [c_REQ_W-1:0]   r_last, w_last_nxt;
    logic [N-1:0]         r_a, w_a_nxt;
    logic [N-1:0]         r_b, w_b_nxt;
    logic [REQ-1:0]       r_gnt, w_gnt_nxt;
    logic [REQ-1:0]       r_done, w_done_nxt;
    logic                 r_lt, w_lt_nxt;
    logic                 r_gt, w_gt_nxt;
    logic                 r_eq, w_eq_nxt;
    logic                 w_lt, w_gt, w_eq;
    logic [c_REQ_W-1:0]   w_win;
    logic [N-1:0]         w_a_arr [REQ];
    logic [N-1:0]         w_b_arr [REQ];

    for (genvar g = 0; g < REQ; g++) begin : g_unpack
        assign w_a_arr[g] = bus.a_in[g*N +: N];
        assign w_b_arr[g] = bus.b_in[g*N +: N];
    end

    // First set request strictly after the last winner, wrapping modulo REQ.
    function automatic logic [c_REQ_W-1:0] f_pick(
        input logic [REQ-1:0]     req_v,
        input logic [c_REQ_W-1:0] last_v
    );
        logic [c_REQ_W-1:0] sel;
        logic [c_REQ_W-1:0] cand;
        logic               found;
        sel   = last_v;
        found = 1'b0;
        for (int i = 1; i <= REQ; i++) begin
            cand = c_REQ_W'((int'(last_v) + i) % REQ);
            if (!found && req_v[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    n_bit_magnitude_comparator #(.N(N)) u_cmp (
        .i_a  (r_a),
        .i_b  (r_b),
        .o_lt (w_lt),
        .o_gt (w_gt),
        .o_eq (w_eq)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_gnt_nxt   = '0;
        w_done_nxt  = '0;
        w_lt_nxt    = r_lt;
        w_gt_nxt    = r_gt;
        w_eq_nxt    = r_eq;
        w_win       = f_pick(bus.req, r_last);
        case (r_state)
            ST_IDLE: begin
                if (|bus.req) begin
                    w_a_nxt     = w_a_arr[w_win];
                    w_b_nxt     = w_b_arr[w_win];
                    w_gnt_nxt   = c_ONE << w_win;
                    w_last_nxt  = w_win;
                    w_state_nxt = ST_CMP;
                end
            end
            ST_CMP: begin
                w_lt_nxt    = w_lt;
                w_gt_nxt    = w_gt;
                w_eq_nxt    = w_eq;
                w_done_nxt  = r_gnt;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= c_REQ_W'(REQ - 1);
            r_a     <= '0;
            r_b     <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_lt    <= 1'b0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_lt    <= w_lt_nxt;
            r_gt    <= w_gt_nxt;
            r_eq    <= w_eq_nxt;
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.done = r_done;
    assign bus.L_T  = r_lt;
    assign bus.G_T  = r_gt;
    assign bus.E    = r_eq;
    assign bus.busy = (r_state == ST_CMP) || (r_state == ST_RESP);

endmodule
`default_nettype wire
